time_base_unit: RTL and testbench
=================================

# time_base_unit

Counting core of the general-purpose timer, directly downstream of the trigger/slave-mode controller. It consumes that block's count clock, reset, gate and trigger strobes, and runs a prescaler plus an up/down counter with auto-reload. It generates the update event, the update interrupt flag, the effective counter enable and one-pulse stop. The update event and counter enable feed back to the trigger controller's master-mode output select.

## Interface
Parameters:
- CNT_W, 16, width of counter, prescaler and auto-reload.

Ports:
- clk_i  in  1  system clock; all state on rising edge
- aresetn_i  in  1  asynchronous active-low reset
- ext_clk_sel_i  in  1  0: one tick per clk_i cycle; 1: one tick per rising edge of cnt_clk_i
- cnt_clk_i  in  1  count clock from slave-mode controller (asynchronous level)
- cen_i  in  1  software counter enable
- gate_mode_i  in  1  slave controller is in gated mode
- sm_reset_i  in  1  slave reset level; rising edge acts
- sm_gate_i  in  1  gate level; counting allowed while 1 (gated mode only)
- sm_trig_i  in  1  slave trigger level; rising edge starts counter
- dir_i  in  1  0 up, 1 down
- opm_i  in  1  one-pulse mode
- arpe_i  in  1  auto-reload preload enable
- udis_i  in  1  update disable
- urs_i  in  1  update request source: 1 = only over/underflow sets UIF
- ug_i  in  1  software update generation, single-cycle pulse
- psc_i  in  CNT_W  prescaler preload value (divide by psc+1)
- arr_i  in  CNT_W  auto-reload preload value
- cnt_o  out  CNT_W  counter value
- uev_o  out  1  update event, one-cycle pulse
- uif_o  out  1  update interrupt flag set request, one-cycle pulse
- cnt_en_o  out  1  effective counting enable (registered)
- cen_clr_o  out  1  one-cycle request to clear CEN (one-pulse stop)

## Operation
- Reset values: cnt_o=0, psc counter=0, psc shadow=0, arr shadow=all ones, start latch=0, all pulse outputs 0, cnt_en_o=0.
- Tick: with ext_clk_sel_i=0, a tick occurs every cycle. With ext_clk_sel_i=1, cnt_clk_i passes a 2-FF synchronizer and a rising-edge detector.
- Start latch: set on rising edge of sm_trig_i; cleared by one-pulse stop.
- Enable: en = (cen_i | start latch) & (~gate_mode_i | sm_gate_i).
- Prescaler: counts ticks while en. When psc_cnt==psc shadow and a tick occurs, psc_cnt returns to 0 and emits ck_cnt.
- Counter, up mode: on ck_cnt, if cnt==arr_eff then cnt=0 with overflow, else cnt+1.
- Counter, down mode: on ck_cnt, if cnt==0 then cnt=arr_eff with underflow, else cnt-1.
- arr_eff is the arr shadow when arpe_i=1, else arr_i directly.
- arr_eff==0: counter holds; no over/underflow events.
- Reinit occurs on ug_i, or on a rising edge of sm_reset_i.
  - psc_cnt=0; cnt=0 (up) or arr_eff (down).
  - Reinit has priority over a same-cycle ck_cnt.
  - Reinit ignores en.
- UEV is caused by overflow, underflow or reinit, and is suppressed entirely when udis_i=1.
- On UEV: psc shadow←psc_i and arr shadow←arr_i.
  - Shadow loads take effect from the next cycle.
  - The counter's own wrap in the UEV cycle uses the old arr_eff.
- UIF: pulses with every UEV when urs_i=0. When urs_i=1, it pulses only on over/underflow UEV.
- One-pulse: opm_i=1 and an over/underflow occurs (udis irrelevant):
  - start latch clears;
  - cen_clr_o pulses;
  - counting stops next cycle.
- Direction change mid-count takes effect at the next ck_cnt; no event is generated.

## Timing
- Internal tick mode: cnt_o changes in the cycle after the ck_cnt cycle (registered).
- uev_o/uif_o assert in the same cycle cnt_o shows the wrapped/reinit value.
- External tick: 3 clk_i cycles from cnt_clk_i rise to tick. The source must hold each level ≥2 clk_i cycles.
- cnt_en_o is en registered, 1-cycle latency.
- ug_i/sm_reset_i edge → cnt_o reinit and uev_o one cycle later.
- aresetn_i mid-count returns everything to reset values immediately; no event pulse.

## Structure
- Shared package gpt_pkg: CNT_W default constant, dir_e (UP, DOWN) typedef.
- Sub-module tb_prescaler: tick, en, clear, psc shadow → ck_cnt. It is instantiated once.
- Synchronizer, edge detectors, shadows, counter and event logic are in the top.

## Test plan
- psc=0, arr=4, up, cen=1: cnt 0,1,2,3,4,0. uev_o/uif_o pulse once per 5 cycles, aligned with cnt_o=0.
- psc=2, arr=3, down: cnt decrements every 3 cycles 3,2,1,0,3. uev on reload.
- arpe=1, running arr=9, write arr_i=4 at cnt=2: wrap still at 9. Next period wraps at 4. With arpe=0, wrap at 4 immediately.
- ug_i at cnt=5 with urs=1: cnt→0, uev_o=1, uif_o=0. Repeat with udis=1: cnt→0, no uev_o/uif_o.
- opm=1, sm_trig rising edge, cen=0, arr=3: counts 0..3,0 then stops. cen_clr_o pulses with the overflow uev; cnt_en_o drops next cycle.
- Gated mode, ext_clk_sel=1, cnt_clk toggling every 4 cycles: counts only while sm_gate_i=1. A sm_reset_i edge at cnt=7 gives cnt 0 plus uev.

Source files
------------

// File: rtl/gpt_pkg.sv
// Shared definitions for the general-purpose timer blocks.
// Holds the default counter width and the count-direction encoding.
package gpt_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/tb_prescaler.sv
// Time-base prescaler: divides qualified ticks by psc+1; ck_cnt_o is combinational, counter registered.
// No backpressure; clr_i restarts the division and overrides a same-cycle tick.
module tb_prescaler #(
    parameter int CNT_W = gpt_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] psc_sh_i,
    output logic             ck_cnt_o
);

    logic [CNT_W-1:0] psc_cnt_q;
    logic [CNT_W-1:0] psc_cnt_d;
    logic             step;
    logic             wrap;

    always_comb begin
        step      = tick_i & en_i;
        wrap      = step & (psc_cnt_q == psc_sh_i);
        ck_cnt_o  = wrap;
        psc_cnt_d = psc_cnt_q;
        if (clr_i || wrap) begin
            psc_cnt_d = '0;
        end else if (step) begin
            psc_cnt_d = psc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/time_base_unit.sv
// Timer counting core: prescaler, up/down counter with auto-reload, update events and one-pulse stop.
// Outputs registered one cycle after the causing tick/strobe; no backpressure, events are single-cycle pulses.
module time_base_unit #(
    parameter int CNT_W = gpt_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic             ext_clk_sel_i,
    input  logic             cnt_clk_i,
    input  logic             cen_i,
    input  logic             gate_mode_i,
    input  logic             sm_reset_i,
    input  logic             sm_gate_i,
    input  logic             sm_trig_i,
    input  logic             dir_i,
    input  logic             opm_i,
    input  logic             arpe_i,
    input  logic             udis_i,
    input  logic             urs_i,
    input  logic             ug_i,
    input  logic [CNT_W-1:0] psc_i,
    input  logic [CNT_W-1:0] arr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             uev_o,
    output logic             uif_o,
    output logic             cnt_en_o,
    output logic             cen_clr_o
);

    import gpt_pkg::*;

    logic [2:0]       cclk_q;
    logic             trig_q;
    logic             srst_q;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] psc_sh_q, psc_sh_d;
    logic [CNT_W-1:0] arr_sh_q, arr_sh_d;
    logic             uev_q, uif_q, cnt_en_q, cen_clr_q;

    dir_e             dir;
    logic             tick;
    logic             en;
    logic             reinit;
    logic             ck_cnt;
    logic [CNT_W-1:0] arr_eff;
    logic             wrap;
    logic             uev;
    logic             uif;
    logic             opm_stop;

    assign dir     = dir_e'(dir_i);
    // cclk_q[1] is the synchronized level, cclk_q[2] its previous value
    assign tick    = ext_clk_sel_i ? (cclk_q[1] & ~cclk_q[2]) : 1'b1;
    assign en      = (cen_i | start_q) & (~gate_mode_i | sm_gate_i);
    assign reinit  = ug_i | (sm_reset_i & ~srst_q);
    assign arr_eff = arpe_i ? arr_sh_q : arr_i;

    tb_prescaler #(
        .CNT_W (CNT_W)
    ) u_psc (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .tick_i    (tick),
        .en_i      (en),
        .clr_i     (reinit),
        .psc_sh_i  (psc_sh_q),
        .ck_cnt_o  (ck_cnt)
    );

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (reinit) begin
            cnt_d = (dir == DOWN) ? arr_eff : '0;
        end else if (ck_cnt && (arr_eff != '0)) begin
            if (dir == UP) begin
                if (cnt_q == arr_eff) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = arr_eff;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Shadows load on the event but the wrap above already used the old arr_eff
    always_comb begin
        uev      = (wrap | reinit) & ~udis_i;
        uif      = uev & (~urs_i | wrap);
        opm_stop = opm_i & wrap;
        start_d  = opm_stop ? 1'b0 : ((sm_trig_i & ~trig_q) ? 1'b1 : start_q);
        psc_sh_d = uev ? psc_i : psc_sh_q;
        arr_sh_d = uev ? arr_i : arr_sh_q;
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cclk_q    <= '0;
            trig_q    <= 1'b0;
            srst_q    <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            psc_sh_q  <= '0;
            arr_sh_q  <= '1;
            uev_q     <= 1'b0;
            uif_q     <= 1'b0;
            cnt_en_q  <= 1'b0;
            cen_clr_q <= 1'b0;
        end else begin
            cclk_q    <= {cclk_q[1:0], cnt_clk_i};
            trig_q    <= sm_trig_i;
            srst_q    <= sm_reset_i;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            psc_sh_q  <= psc_sh_d;
            arr_sh_q  <= arr_sh_d;
            uev_q     <= uev;
            uif_q     <= uif;
            cnt_en_q  <= en;
            cen_clr_q <= opm_stop;
        end
    end

    assign cnt_o     = cnt_q;
    assign uev_o     = uev_q;
    assign uif_o     = uif_q;
    assign cnt_en_o  = cnt_en_q;
    assign cen_clr_o = cen_clr_q;

endmodule

// File: tb/tb_time_base_unit.sv
// Self-checking bench for time_base_unit: vector table for free-running up/down counting,
// hand sequences for preload, software update, one-pulse and gated external-clock cases.
module tb_time_base_unit;

    logic        clk_i = 1'b0;
    logic        aresetn_i = 1'b0;
    logic        ext_clk_sel_i = 1'b0, cnt_clk_i = 1'b0, cen_i = 1'b0, gate_mode_i = 1'b0;
    logic        sm_reset_i = 1'b0, sm_gate_i = 1'b0, sm_trig_i = 1'b0, dir_i = 1'b0;
    logic        opm_i = 1'b0, arpe_i = 1'b0, udis_i = 1'b0, urs_i = 1'b0, ug_i = 1'b0;
    logic [15:0] psc_i = '0, arr_i = '0;
    logic [15:0] cnt_o;
    logic        uev_o, uif_o, cnt_en_o, cen_clr_o;

    always #5 clk_i = ~clk_i;

    time_base_unit dut (
        .clk_i         (clk_i),
        .aresetn_i     (aresetn_i),
        .ext_clk_sel_i (ext_clk_sel_i),
        .cnt_clk_i     (cnt_clk_i),
        .cen_i         (cen_i),
        .gate_mode_i   (gate_mode_i),
        .sm_reset_i    (sm_reset_i),
        .sm_gate_i     (sm_gate_i),
        .sm_trig_i     (sm_trig_i),
        .dir_i         (dir_i),
        .opm_i         (opm_i),
        .arpe_i        (arpe_i),
        .udis_i        (udis_i),
        .urs_i         (urs_i),
        .ug_i          (ug_i),
        .psc_i         (psc_i),
        .arr_i         (arr_i),
        .cnt_o         (cnt_o),
        .uev_o         (uev_o),
        .uif_o         (uif_o),
        .cnt_en_o      (cnt_en_o),
        .cen_clr_o     (cen_clr_o)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic        uev;
        logic        uif;
        logic        en;
        logic        clr;
    } exp_t;

    typedef struct packed {
        logic        cen;
        logic        dir;
        logic        ug;
        logic [15:0] psc;
        logic [15:0] arr;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic exp_t ex(input int c, input logic u, input logic f, input logic n, input logic r);
        exp_t e;
        e.cnt = 16'(c);
        e.uev = u;
        e.uif = f;
        e.en  = n;
        e.clr = r;
        return e;
    endfunction

    function automatic vec_t mk(input logic cen, input logic dir, input logic ug,
                                input int psc, input int arr, input exp_t e);
        vec_t v;
        v.cen = cen;
        v.dir = dir;
        v.ug  = ug;
        v.psc = 16'(psc);
        v.arr = 16'(arr);
        v.e   = e;
        return v;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        exp_t a;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            a = {cnt_o, uev_o, uif_o, cnt_en_o, cen_clr_o};
            if (a !== e) begin
                tests_failed++;
                $display("FAIL %s: got cnt=%0d uev=%b uif=%b en=%b clr=%b, want cnt=%0d uev=%b uif=%b en=%b clr=%b",
                         tag, a.cnt, a.uev, a.uif, a.en, a.clr, e.cnt, e.uev, e.uif, e.en, e.clr);
            end
        end
    endtask

    // Inputs are already driven; push the expectation, clock once, compare after the edge.
    task automatic cyc(input string tag, input exp_t e);
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        check_out(tag);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        ext_clk_sel_i = 1'b0; cnt_clk_i = 1'b0; cen_i = 1'b0; gate_mode_i = 1'b0;
        sm_reset_i = 1'b0; sm_gate_i = 1'b0; sm_trig_i = 1'b0; dir_i = 1'b0;
        opm_i = 1'b0; arpe_i = 1'b0; udis_i = 1'b0; urs_i = 1'b0; ug_i = 1'b0;
        psc_i = '0; arr_i = '0;
        aresetn_i = 1'b0;
        #1;
        tests_run++;
        if ({cnt_o, uev_o, uif_o, cnt_en_o, cen_clr_o} !== 20'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got cnt=%0d uev=%b uif=%b en=%b clr=%b, want all zero",
                     cnt_o, uev_o, uif_o, cnt_en_o, cen_clr_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        aresetn_i = 1'b1;
    endtask

    vec_t tbl[23];
    logic xh[80];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ecnt;
        logic g;
        logic tk;

        // psc=0 arr=4 up, then ug with down/psc=2/arr=3 and free-run down
        tbl[0]  = mk(1, 0, 0, 0, 4, ex(1, 0, 0, 1, 0));
        tbl[1]  = mk(1, 0, 0, 0, 4, ex(2, 0, 0, 1, 0));
        tbl[2]  = mk(1, 0, 0, 0, 4, ex(3, 0, 0, 1, 0));
        tbl[3]  = mk(1, 0, 0, 0, 4, ex(4, 0, 0, 1, 0));
        tbl[4]  = mk(1, 0, 0, 0, 4, ex(0, 1, 1, 1, 0));
        tbl[5]  = mk(1, 0, 0, 0, 4, ex(1, 0, 0, 1, 0));
        tbl[6]  = mk(1, 0, 0, 0, 4, ex(2, 0, 0, 1, 0));
        tbl[7]  = mk(1, 0, 0, 0, 4, ex(3, 0, 0, 1, 0));
        tbl[8]  = mk(1, 0, 0, 0, 4, ex(4, 0, 0, 1, 0));
        tbl[9]  = mk(1, 0, 0, 0, 4, ex(0, 1, 1, 1, 0));
        tbl[10] = mk(1, 1, 1, 2, 3, ex(3, 1, 1, 1, 0));
        tbl[11] = mk(1, 1, 0, 2, 3, ex(3, 0, 0, 1, 0));
        tbl[12] = mk(1, 1, 0, 2, 3, ex(3, 0, 0, 1, 0));
        tbl[13] = mk(1, 1, 0, 2, 3, ex(2, 0, 0, 1, 0));
        tbl[14] = mk(1, 1, 0, 2, 3, ex(2, 0, 0, 1, 0));
        tbl[15] = mk(1, 1, 0, 2, 3, ex(2, 0, 0, 1, 0));
        tbl[16] = mk(1, 1, 0, 2, 3, ex(1, 0, 0, 1, 0));
        tbl[17] = mk(1, 1, 0, 2, 3, ex(1, 0, 0, 1, 0));
        tbl[18] = mk(1, 1, 0, 2, 3, ex(1, 0, 0, 1, 0));
        tbl[19] = mk(1, 1, 0, 2, 3, ex(0, 0, 0, 1, 0));
        tbl[20] = mk(1, 1, 0, 2, 3, ex(0, 0, 0, 1, 0));
        tbl[21] = mk(1, 1, 0, 2, 3, ex(0, 0, 0, 1, 0));
        tbl[22] = mk(1, 1, 0, 2, 3, ex(3, 1, 1, 1, 0));

        do_reset();
        for (int i = 0; i < 23; i++) begin
            cen_i = tbl[i].cen;
            dir_i = tbl[i].dir;
            ug_i  = tbl[i].ug;
            psc_i = tbl[i].psc;
            arr_i = tbl[i].arr;
            cyc($sformatf("vec%0d", i), tbl[i].e);
        end

        // Auto-reload preload: a mid-period arr write only lands at the next update
        do_reset();
        arpe_i = 1'b1; arr_i = 16'd9; ug_i = 1'b1;
        cyc("arpe_ug", ex(0, 1, 1, 0, 0));
        ug_i = 1'b0; cen_i = 1'b1;
        cyc("arpe_c1", ex(1, 0, 0, 1, 0));
        cyc("arpe_c2", ex(2, 0, 0, 1, 0));
        arr_i = 16'd4;
        for (int k = 3; k <= 9; k++) cyc($sformatf("arpe_up%0d", k), ex(k, 0, 0, 1, 0));
        cyc("arpe_wrap9", ex(0, 1, 1, 1, 0));
        cyc("arpe_p2_1", ex(1, 0, 0, 1, 0));
        cyc("arpe_p2_2", ex(2, 0, 0, 1, 0));
        arr_i = 16'd9;
        cyc("arpe_p2_3", ex(3, 0, 0, 1, 0));
        cyc("arpe_p2_4", ex(4, 0, 0, 1, 0));
        cyc("arpe_wrap4", ex(0, 1, 1, 1, 0));
        arpe_i = 1'b0;
        cyc("direct_1", ex(1, 0, 0, 1, 0));
        cyc("direct_2", ex(2, 0, 0, 1, 0));
        arr_i = 16'd4;
        cyc("direct_3", ex(3, 0, 0, 1, 0));
        cyc("direct_4", ex(4, 0, 0, 1, 0));
        cyc("direct_wrap4", ex(0, 1, 1, 1, 0));

        // Software update with urs / udis, overflow with urs / udis, arr=0 hold
        arr_i = 16'd9;
        for (int k = 1; k <= 5; k++) cyc($sformatf("ug_pre%0d", k), ex(k, 0, 0, 1, 0));
        ug_i = 1'b1; urs_i = 1'b1;
        cyc("ug_urs", ex(0, 1, 0, 1, 0));
        ug_i = 1'b0;
        for (int k = 1; k <= 5; k++) cyc($sformatf("ug_mid%0d", k), ex(k, 0, 0, 1, 0));
        ug_i = 1'b1; udis_i = 1'b1;
        cyc("ug_udis", ex(0, 0, 0, 1, 0));
        ug_i = 1'b0; udis_i = 1'b0;
        for (int k = 1; k <= 9; k++) cyc($sformatf("urs_up%0d", k), ex(k, 0, 0, 1, 0));
        cyc("urs_ovf", ex(0, 1, 1, 1, 0));
        urs_i = 1'b0; udis_i = 1'b1;
        for (int k = 1; k <= 9; k++) cyc($sformatf("udis_up%0d", k), ex(k, 0, 0, 1, 0));
        cyc("udis_ovf", ex(0, 0, 0, 1, 0));
        udis_i = 1'b0; arr_i = 16'd0;
        for (int k = 0; k < 3; k++) cyc($sformatf("arr0_hold%0d", k), ex(0, 0, 0, 1, 0));

        // One-pulse mode started by a trigger edge
        do_reset();
        opm_i = 1'b1; arr_i = 16'd3; sm_trig_i = 1'b1;
        cyc("opm_trig", ex(0, 0, 0, 0, 0));
        cyc("opm_1", ex(1, 0, 0, 1, 0));
        cyc("opm_2", ex(2, 0, 0, 1, 0));
        cyc("opm_3", ex(3, 0, 0, 1, 0));
        cyc("opm_stop", ex(0, 1, 1, 1, 1));
        cyc("opm_en_drop", ex(0, 0, 0, 0, 0));
        cyc("opm_idle", ex(0, 0, 0, 0, 0));

        // Gated mode with external clock, then a slave reset edge at cnt=7
        do_reset();
        ext_clk_sel_i = 1'b1; gate_mode_i = 1'b1; cen_i = 1'b1; arr_i = 16'd100;
        ecnt = 0;
        for (int k = 0; k < 80; k++) begin
            xh[k]      = ((k / 4) % 2) == 1;
            cnt_clk_i  = xh[k];
            g          = !(k >= 24 && k < 40);
            sm_gate_i  = g;
            sm_reset_i = (k >= 72);
            tk = 1'b0;
            if (k >= 3) tk = xh[k-2] && !xh[k-3];
            if (k == 72) ecnt = 0;
            else if (tk && g) ecnt++;
            cyc($sformatf("gate%0d", k), ex(ecnt, k == 72, k == 72, g, 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
